// File: rtl/dmem_pkg.sv
//============================================================================
// Module   : dmem_pkg
// Purpose  : State encodings, byte-enable constants and the address check
//            shared by the data-memory responder.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Range is checked on the full offset so that nothing wraps into the array.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [3:0]  be,
                                    input logic [31:0] base,
                                    input int unsigned depth_words);
    logic [31:0] off;
    logic        bad;
    off = addr - base;
    bad = (addr < base) || ((off >> 2) >= depth_words);
    if (be == BE_WORD && addr[1:0] != 2'b00)
      bad = 1'b1;
    if ((be == BE_HALF_LO || be == BE_HALF_HI) && addr[0])
      bad = 1'b1;
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
//============================================================================
// Module   : dmem_if
// Purpose  : Load/store request and response bundle between core and memory.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_byte_array.sv
//============================================================================
// Module   : dmem_byte_array
// Purpose  : Word storage with byte-lane writes and a registered read port.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module dmem_byte_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
`ifdef DMEM_RESPONDER_TRACE_EN
  ,
  input  logic          reset,
  input  logic          hs
`endif
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Read data only moves on a load, so it stays put while a response waits.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i])
            r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[idx];
      end
    end
  end

  assign rdata = r_rdata;

`ifdef DMEM_RESPONDER_TRACE_EN
  logic [31:0] access_count;

  always_ff @(posedge clk) begin
    if (!reset)
      access_count <= '0;
    else if (hs)
      access_count <= access_count + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//============================================================================
// Module   : dmem_responder
// Purpose  : Wait-state data-memory slave; optional DMEM_RESPONDER_TRACE_EN
//            adds a handshake trace and an access counter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  dmem_state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we, r_err;
  logic        w_accept, w_hs, w_in_err, w_rsp_valid, w_do_access, w_arr_en;
  logic        w_acc_we, w_acc_err;
  logic [31:0] w_acc_addr, w_acc_wdata, w_arr_rdata;
  logic [3:0]  w_acc_be;
  logic [AW-1:0] w_idx;

  assign bus.req_ready = reset && (r_state == IDLE);
  assign w_rsp_valid   = reset && (r_state == RESP);
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_err   = w_rsp_valid && r_err;
  assign bus.rsp_rdata = (w_rsp_valid && !r_we && !r_err) ? w_arr_rdata : 32'h0;

  assign w_accept = bus.req_valid && reset && (r_state == IDLE);
  assign w_hs     = w_rsp_valid && bus.rsp_ready;
  assign w_in_err = addr_err(bus.req_addr, bus.req_be, BASE_ADDR, DEPTH_WORDS);

  // With no wait states the access happens on the accepting edge itself.
  generate
    if (WAIT_CYCLES == 0) begin : g_direct
      assign w_acc_we    = bus.req_we;
      assign w_acc_err   = w_in_err;
      assign w_acc_addr  = bus.req_addr;
      assign w_acc_wdata = bus.req_wdata;
      assign w_acc_be    = bus.req_be;
      assign w_do_access = w_accept;
    end else begin : g_staged
      logic [31:0] r_addr, r_wdata;
      logic [3:0]  r_be;
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_be    <= bus.req_be;
        end
      end
      assign w_acc_we    = r_we;
      assign w_acc_err   = r_err;
      assign w_acc_addr  = r_addr;
      assign w_acc_wdata = r_wdata;
      assign w_acc_be    = r_be;
      assign w_do_access = reset && (r_state == WAIT) && (r_cnt == 4'd1);
    end
  endgenerate

  assign w_arr_en = w_do_access && !w_acc_err;
  assign w_idx    = AW'((w_acc_addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 4'd0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= c_wait;
      r_we  <= bus.req_we;
      r_err <= w_in_err;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  dmem_byte_array #(.DEPTH_WORDS(DEPTH_WORDS)) dmem (
    .clk   (clk),
    .en    (w_arr_en),
    .we    (w_acc_we),
    .be    (w_acc_be),
    .idx   (w_idx),
    .wdata (w_acc_wdata),
    .rdata (w_arr_rdata)
`ifdef DMEM_RESPONDER_TRACE_EN
    ,
    .reset (reset),
    .hs    (w_hs)
`endif
  );

`ifdef DMEM_RESPONDER_TRACE_EN
  logic [31:0] r_trc_addr, r_trc_wdata;
  logic [3:0]  r_trc_be;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_trc_addr  <= bus.req_addr;
      r_trc_wdata <= bus.req_wdata;
      r_trc_be    <= bus.req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_hs)
      $display("[CLK %0t] dmem %s addr=%08h be=%04b data=%08h err=%0b", $time,
               r_we ? "W" : "R", r_trc_addr, r_trc_be,
               r_we ? r_trc_wdata : bus.rsp_rdata, r_err);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed and random checks of dmem_responder against a word model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0))
    dut (.clk(clk), .reset(reset), .bus(bus));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h100))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [3:0] be,
                                   input logic [31:0] base, input int unsigned depth);
    if (a < base) return 1'b1;
    if ((a - base) / 4 >= depth) return 1'b1;
    if (be == 4'hF && a % 4 != 0) return 1'b1;
    if ((be == 4'h3 || be == 4'hC) && a % 2 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One transaction on the wait-state DUT; starts and ends just after a negedge.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_be = be;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom; bus.req_wdata = $urandom; bus.req_we = ~we;
    chk("busy_after_accept", 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = bus.rsp_rdata; er = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rdata", bus.rsp_rdata, rd);
      chk("bp_err", 32'(bus.rsp_err), 32'(er));
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("ready_rise", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int hold);
    logic [31:0] rd, exp_rd;
    logic        er, e;
    int          lat;
    e      = exp_err(a, be, 32'h0, 256);
    exp_rd = (we || e) ? 32'h0 : model[a[9:2]];
    xact(we, a, wd, be, hold, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, 32'(er), 32'(e));
    chk({tag, "_rdata"}, rd, exp_rd);
    if (we && !e) model[a[9:2]] = merge(model[a[9:2]], wd, be);
  endtask

  task automatic xact0(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e);
    int lat;
    bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_addr = a;
    bus0.req_wdata = wd;   bus0.req_be = 4'hF;
    chk({tag, "_ready"}, 32'(bus0.req_ready), 32'd1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    lat = 1;
    while (!bus0.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(bus0.rsp_err), 32'(exp_e));
    chk({tag, "_rdata"}, bus0.rsp_rdata, exp_rd);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    chk({tag, "_ready_back"}, 32'(bus0.req_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] a;
    int          w;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_be = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_be = 0; bus0.rsp_ready = 0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    run("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    run("ld_word", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    run("st_byte", 1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
    run("ld_byte", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    run("st_bp", 1'b1, 32'h10, 32'h11223344, 4'hC, 5);
    run("ld_bp", 1'b0, 32'h10, 32'h0, 4'hF, 5);

    run("st_last", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0);
    run("ld_mis", 1'b0, 32'h12, 32'h0, 4'hF, 0);
    run("st_oor", 1'b1, 32'h400, 32'h12345678, 4'hF, 0);
    run("st_mis_last", 1'b1, 32'h3FD, 32'h87654321, 4'hF, 0);
    run("st_half_mis", 1'b1, 32'h3FD, 32'h87654321, 4'h3, 0);
    run("ld_last", 1'b0, 32'h3FC, 32'h0, 4'hF, 0);
    run("st_half_hi", 1'b1, 32'h12, 32'h99880000, 4'hC, 0);
    run("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
    run("ld_be0", 1'b0, 32'h13, 32'h0, 4'h0, 0);

    // Abort a store while it is still counting down.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h55555555; bus.req_be = 4'hF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1 chk("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
    seen = 1'b0;
    @(negedge clk);
    seen |= bus.rsp_valid;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= bus.rsp_valid; end
    chk("rstmid_no_rsp", 32'(seen), 32'd0);
    run("ld_after_abort", 1'b0, 32'h10, 32'h0, 4'hF, 0);

    for (int i = 0; i < 16; i++) run("rnd_init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < 50; i++) begin
      w = $urandom_range(0, 19);
      if (w >= 16) w = (w == 16) ? 255 : (w == 17) ? 256 : 300;
      a = 32'(w * 4 + $urandom_range(0, 3));
      run("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 2)));
    end

    xact0("z_st", 1'b1, 32'h104, 32'h12345678, 32'h0, 1'b0);
    xact0("z_ld", 1'b0, 32'h104, 32'h0, 32'h12345678, 1'b0);
    xact0("z_below", 1'b0, 32'h0FC, 32'h0, 32'h0, 1'b1);
    xact0("z_above", 1'b1, 32'h140, 32'h0BADF00D, 32'h0, 1'b1);
    xact0("z_st_top", 1'b1, 32'h13C, 32'hA5A5C3C3, 32'h0, 1'b0);
    xact0("z_ld_top", 1'b0, 32'h13C, 32'h0, 32'hA5A5C3C3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
